// File: rtl/logical_bist_ctrl.sv
// BIST sequencer for the shared logical-operator unit: sweeps all {b,a} vectors and checks and/or/not.
// Optional LOGICAL_BIST_STOP_ON_FAIL_EN ends the run on the first failing vector.
module logical_bist_ctrl #(
  parameter int WIDTH = 1,
  parameter int HOLD  = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  output logic [WIDTH-1:0]   dut_a,
  output logic [WIDTH-1:0]   dut_b,
  input  logic               dut_and,
  input  logic               dut_or,
  input  logic               dut_not,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [7:0]         err_cnt,
  output logic               fail_valid,
  output logic [2*WIDTH-1:0] fail_vec
);
  localparam int VW = 2 * WIDTH;
  localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [VW-1:0] VEC_LAST  = {VW{1'b1}};
  localparam logic [VW-1:0] VEC_ONE   = VW'(1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD - 1);
  localparam logic [HW-1:0] HOLD_ONE  = HW'(1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [VW-1:0]    vec_q, vec_d;
  logic [HW-1:0]    hold_q, hold_d;
  logic [WIDTH-1:0] dut_a_q, dut_a_d, dut_b_q, dut_b_d;
  logic             busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic [7:0]       err_cnt_q, err_cnt_d;
  logic             fail_valid_q, fail_valid_d;
  logic [VW-1:0]    fail_vec_q, fail_vec_d;
  logic             mismatch, stop_now;

  // The unit sees the registered operands, so its results line up with vec_q.
  always_comb begin
    mismatch = (dut_and != ((|dut_a_q) && (|dut_b_q))) ||
               (dut_or  != ((|dut_a_q) || (|dut_b_q))) ||
               (dut_not != ~(|dut_a_q));
  end

`ifdef LOGICAL_BIST_STOP_ON_FAIL_EN
  assign stop_now = mismatch;
`else
  assign stop_now = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    vec_d        = vec_q;
    hold_d       = hold_q;
    busy_d       = 1'b0;
    done_d       = 1'b0;
    pass_d       = pass_q;
    err_cnt_d    = err_cnt_q;
    fail_valid_d = fail_valid_q;
    fail_vec_d   = fail_vec_q;
    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          state_d      = S_RUN;
          busy_d       = 1'b1;
          vec_d        = '0;
          hold_d       = '0;
          pass_d       = 1'b0;
          err_cnt_d    = '0;
          fail_valid_d = 1'b0;
          fail_vec_d   = '0;
        end
      end
      S_RUN: begin
        if (abort) begin
          state_d = S_IDLE;
          pass_d  = 1'b0;
          vec_d   = '0;
          hold_d  = '0;
        end else if (hold_q == HOLD_LAST) begin
          hold_d = '0;
          busy_d = 1'b1;
          if (mismatch) begin
            if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
            if (!fail_valid_q) begin
              fail_valid_d = 1'b1;
              fail_vec_d   = vec_q;
            end
          end
          if (vec_q == VEC_LAST || stop_now) begin
            state_d = S_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (err_cnt_d == 8'd0);
            vec_d   = '0;
          end else begin
            vec_d = vec_q + VEC_ONE;
          end
        end else begin
          hold_d = hold_q + HOLD_ONE;
          busy_d = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        if (abort) pass_d = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
    dut_a_d = busy_d ? vec_d[WIDTH-1:0]  : '0;
    dut_b_d = busy_d ? vec_d[VW-1:WIDTH] : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      vec_q        <= '0;
      hold_q       <= '0;
      dut_a_q      <= '0;
      dut_b_q      <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      err_cnt_q    <= '0;
      fail_valid_q <= 1'b0;
      fail_vec_q   <= '0;
    end else begin
      state_q      <= state_d;
      vec_q        <= vec_d;
      hold_q       <= hold_d;
      dut_a_q      <= dut_a_d;
      dut_b_q      <= dut_b_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      err_cnt_q    <= err_cnt_d;
      fail_valid_q <= fail_valid_d;
      fail_vec_q   <= fail_vec_d;
    end
  end

  assign dut_a      = dut_a_q;
  assign dut_b      = dut_b_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign err_cnt    = err_cnt_q;
  assign fail_valid = fail_valid_q;
  assign fail_vec   = fail_vec_q;
endmodule
